uart_frame_receiver: RTL

//   Consumes bytes from the Uart8 receiver and assembles framed commands for the image pipeline.

---
 rtl/uart_frame_receiver.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_receiver.sv
// rtl/uart_frame_receiver.sv - UART byte stream to framed command receiver with payload buffer
module uart_frame_receiver #(
    parameter int          MAX_LEN     = 16,
    parameter int          TIMEOUT_CYC = 260000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    localparam int         AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int         TW          = $clog2(TIMEOUT_CYC + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          rx_err,
    output logic          frame_ready,
    output logic [7:0]    frame_cmd,
    output logic [7:0]    frame_len,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_pulse,
    output logic [2:0]    err_code,
    output logic [7:0]    ovr_count,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_HOLD
    } state_t;

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);

    state_t        state, state_nxt;
    logic          rx_done_q;
    logic [TW-1:0] timer;
    logic [7:0]    cmd_q, len_q, chk_q, idx_q;
    logic [7:0]    pay_mem [MAX_LEN];

    logic          ev, active, timed_out, byte_ok;
    logic          err_set;
    logic [2:0]    err_val;

    assign ev        = rx_done & ~rx_done_q;
    assign active    = (state != S_IDLE) && (state != S_HOLD);
    assign timed_out = active && (timer >= TMO_LIMIT);
    assign byte_ok   = ev & ~rx_err & ~timed_out;
    assign busy      = active;

    // Next-state and error selection; rx_err beats timeout beats a byte event.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_val   = 3'd0;
        case (state)
            S_IDLE: begin
                if (ev && !rx_err && rx_data == SYNC_BYTE)
                    state_nxt = S_CMD;
            end
            S_HOLD: begin
                if (frame_ack)
                    state_nxt = S_IDLE;
                if (ev && !rx_err) begin
                    err_set = 1'b1;
                    err_val = 3'd5;
                end
            end
            default: begin
                if (rx_err) begin
                    err_set   = 1'b1;
                    err_val   = 3'd4;
                    state_nxt = S_IDLE;
                end else if (timed_out) begin
                    err_set   = 1'b1;
                    err_val   = 3'd3;
                    state_nxt = S_IDLE;
                end else if (ev) begin
                    case (state)
                        S_CMD: state_nxt = S_LEN;
                        S_LEN: begin
                            if (rx_data > MAX_LEN_B) begin
                                err_set   = 1'b1;
                                err_val   = 3'd2;
                                state_nxt = S_IDLE;
                            end else if (rx_data == 8'd0) begin
                                state_nxt = S_CHK;
                            end else begin
                                state_nxt = S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            if (idx_q == len_q - 8'd1)
                                state_nxt = S_CHK;
                        end
                        S_CHK: begin
                            if (rx_data == chk_q) begin
                                state_nxt = S_HOLD;
                            end else begin
                                err_set   = 1'b1;
                                err_val   = 3'd1;
                                state_nxt = S_IDLE;
                            end
                        end
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // State, timer, frame fields, checksum and error/overrun bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rx_done_q   <= 1'b1;
            timer       <= '0;
            cmd_q       <= 8'd0;
            len_q       <= 8'd0;
            chk_q       <= 8'd0;
            idx_q       <= 8'd0;
            frame_ready <= 1'b0;
            frame_cmd   <= 8'd0;
            frame_len   <= 8'd0;
            err_pulse   <= 1'b0;
            err_code    <= 3'd0;
            ovr_count   <= 8'd0;
            rd_data     <= 8'd0;
        end else begin
            state     <= state_nxt;
            rx_done_q <= rx_done;
            err_pulse <= err_set;
            rd_data   <= pay_mem[rd_addr];
            if (err_set)
                err_code <= err_val;

            if (!active || ev || timed_out)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (state == S_HOLD && ev && !rx_err && ovr_count != 8'hFF)
                ovr_count <= ovr_count + 8'd1;

            if (state == S_HOLD && frame_ack)
                frame_ready <= 1'b0;

            if (byte_ok) begin
                case (state)
                    S_CMD: begin
                        cmd_q <= rx_data;
                        chk_q <= rx_data;
                    end
                    S_LEN: begin
                        len_q <= rx_data;
                        chk_q <= chk_q ^ rx_data;
                        idx_q <= 8'd0;
                    end
                    S_PAYLOAD: begin
                        chk_q <= chk_q ^ rx_data;
                        idx_q <= idx_q + 8'd1;
                    end
                    S_CHK: begin
                        if (rx_data == chk_q) begin
                            frame_ready <= 1'b1;
                            frame_cmd   <= cmd_q;
                            frame_len   <= len_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Payload buffer write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && byte_ok && state == S_PAYLOAD)
            pay_mem[idx_q[AW-1:0]] <= rx_data;
    end

endmodule
